// File: rtl/li_sequencer.sv
// Expands a 32-bit load-immediate into lui/addiu words (one or two).
// Latency: first word valid the cycle after accept; one word per out handshake.
// Backpressure: out_instr/out_last held while out_ready low; in_ready only in IDLE.
module li_sequencer #(
    parameter logic [5:0] OPC_ADDIU    = 6'b001001,
    parameter logic [5:0] OPC_LUI      = 6'b001111,
    parameter bit         DROP_ZERO_RT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_value,
    input  logic [4:0]  in_rt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_last
);

    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

    state_t      state_q, state_d;
    logic [4:0]  rt_q, rt_d;
    logic [15:0] lo_q, lo_d;
    logic        two_q, two_d;
    logic [31:0] instr_q, instr_d;
    logic        last_q, last_d;

    logic [15:0] v_lo, v_hi, hiadj;
    logic        fits16, accept, drop;

    assign v_lo   = in_value[15:0];
    assign v_hi   = in_value[31:16];
    // The low half is sign-extended by addiu, so lui must pre-compensate by +1
    // when bit 15 is set; the 16-bit wrap is exact modulo 2^32.
    assign hiadj  = v_hi + {15'd0, v_lo[15]};
    // A lone addiu suffices when the value is its own sign-extended low half.
    assign fits16 = (&in_value[31:15]) || (~|in_value[31:15]);
    assign accept = in_valid && (state_q == IDLE);
    assign drop   = DROP_ZERO_RT && (in_rt == 5'd0);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q != IDLE);
    assign out_instr = instr_q;
    assign out_last  = last_q;

    // State register and latched plan/output word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rt_q    <= 5'd0;
            lo_q    <= 16'd0;
            two_q   <= 1'b0;
            instr_q <= 32'd0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rt_q    <= rt_d;
            lo_q    <= lo_d;
            two_q   <= two_d;
            instr_q <= instr_d;
            last_q  <= last_d;
        end
    end

    // Next-state: plan the sequence at accept, advance on each out handshake.
    always_comb begin
        state_d = state_q;
        rt_d    = rt_q;
        lo_d    = lo_q;
        two_d   = two_q;
        instr_d = instr_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept && !drop) begin
                    state_d = EMIT1;
                    rt_d    = in_rt;
                    lo_d    = v_lo;
                    if (fits16) begin
                        instr_d = {OPC_ADDIU, 5'd0, in_rt, v_lo};
                        two_d   = 1'b0;
                        last_d  = 1'b1;
                    end else if (v_lo == 16'd0) begin
                        instr_d = {OPC_LUI, 5'd0, in_rt, v_hi};
                        two_d   = 1'b0;
                        last_d  = 1'b1;
                    end else begin
                        instr_d = {OPC_LUI, 5'd0, in_rt, hiadj};
                        two_d   = 1'b1;
                        last_d  = 1'b0;
                    end
                end
            end
            EMIT1: begin
                if (out_ready) begin
                    if (two_q) begin
                        state_d = EMIT2;
                        instr_d = {OPC_ADDIU, rt_q, rt_q, lo_q};
                        last_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        instr_d = 32'd0;
                        last_d  = 1'b0;
                    end
                end
            end
            EMIT2: begin
                if (out_ready) begin
                    state_d = IDLE;
                    instr_d = 32'd0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_li_sequencer.sv
// Directed + randomized bench for li_sequencer with an expected-word queue.
// Inputs driven and outputs sampled on the falling clock edge.
// Covers single/double word plans, backpressure, dropped rt=0 and mid-sequence reset.
module tb_li_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic [4:0]  in_rt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;

    typedef struct packed {
        logic [31:0] instr;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    li_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_rt     (in_rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference plan: pushes the expected words for one request.
    task automatic push_plan(input logic [31:0] v, input logic [4:0] rt);
        logic [15:0] lo, hi, hiadj;
        exp_t e;
        lo = v[15:0];
        hi = v[31:16];
        if (rt == 5'd0) return;
        if ($signed({{16{lo[15]}}, lo}) == $signed(v)) begin
            e.instr = {6'b001001, 5'd0, rt, lo}; e.last = 1'b1; exp_q.push_back(e);
        end else if (lo == 16'd0) begin
            e.instr = {6'b001111, 5'd0, rt, hi}; e.last = 1'b1; exp_q.push_back(e);
        end else begin
            hiadj = hi + (lo[15] ? 16'd1 : 16'd0);
            e.instr = {6'b001111, 5'd0, rt, hiadj}; e.last = 1'b0; exp_q.push_back(e);
            e.instr = {6'b001001, rt, rt, lo};      e.last = 1'b1; exp_q.push_back(e);
        end
    endtask

    // Issue one request and drain its words; bp holds out_ready low 3 cycles per word.
    task automatic run(input logic [31:0] v, input logic [4:0] rt, input bit bp);
        int budget;
        exp_t e;
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        in_value  = v;
        in_rt     = rt;
        out_ready = !bp;
        push_plan(v, rt);
        @(negedge clk);
        in_valid = 1'b0;
        in_value = $urandom;
        in_rt    = 5'($urandom);
        if (exp_q.size() == 0) begin
            check("drop_out_valid", out_valid, 0);
            check("drop_in_ready", in_ready, 1);
            @(negedge clk);
            check("drop_out_valid2", out_valid, 0);
            return;
        end
        check("latency1_valid", out_valid, 1);
        budget = 40;
        while (exp_q.size() > 0 && budget > 0) begin
            if (!out_valid) begin
                budget--;
                @(negedge clk);
                continue;
            end
            e = exp_q[0];
            check("in_ready_busy", in_ready, 0);
            if (bp) begin
                out_ready = 1'b0;
                repeat (3) begin
                    check("hold_instr", out_instr, e.instr);
                    check("hold_last", out_last, e.last);
                    in_value = $urandom;
                    @(negedge clk);
                end
            end
            check("instr", out_instr, e.instr);
            check("last", out_last, e.last);
            void'(exp_q.pop_front());
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = !bp;
        end
        check("words_left", exp_q.size(), 0);
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        exp_t e;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_value  = 32'd0;
        in_rt     = 5'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_instr", out_instr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);

        run(32'h00000005, 5'd8,  1'b0);
        run(32'hFFFF8000, 5'd9,  1'b0);
        run(32'h00007FFF, 5'd9,  1'b0);
        run(32'h12340000, 5'd10, 1'b0);
        run(32'h12348765, 5'd10, 1'b0);
        run(32'h0000FFFF, 5'd10, 1'b0);
        run(32'h7FFF8000, 5'd10, 1'b0);
        run(32'h12348765, 5'd10, 1'b1);
        run(32'h12345678, 5'd0,  1'b0);

        // Reset during the second word of a two-word sequence.
        @(negedge clk);
        in_valid  = 1'b1;
        in_value  = 32'hCAFE1234;
        in_rt     = 5'd3;
        out_ready = 1'b1;
        push_plan(32'hCAFE1234, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        e = exp_q.pop_front();
        check("rstmid_w1", out_instr, e.instr);
        @(negedge clk);
        e = exp_q.pop_front();
        check("rstmid_emit2_valid", out_valid, 1);
        check("rstmid_emit2_instr", out_instr, e.instr);
        rst_n     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("rstmid_valid", out_valid, 0);
        check("rstmid_instr", out_instr, 0);
        check("rstmid_in_ready", in_ready, 1);
        @(negedge clk);
        check("rstmid_valid2", out_valid, 0);
        exp_q.delete();
        run(32'h00000005, 5'd8, 1'b0);

        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            case (i % 4)
                1: v = {{16{v[15]}}, v[15:0]};
                2: v[15:0] = 16'd0;
                default: ;
            endcase
            run(v, 5'($urandom_range(1, 31)), (i % 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
